// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard and forwarding controller for the pipelined RINSC datapath.
//   Keeps a small scoreboard of the instructions in flight after ID
//   (entry 0 = EX, entry 1 = MEM, ..., entry NSTAGE-1 = WB).
//   From that scoreboard it derives:
//     - load-use stalls, for any load latency;
//     - a one-cycle IF/ID flush on taken jumps;
//     - nearest-stage forwarding selects for both EX operands.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_ra / id_rb         source register indices
//   id_use_ra / id_use_rb source read flags
//   id_rd                 destination index
//   id_regwrite           instruction writes the register file
//   id_memread            instruction is a load
//   id_jump               taken jump resolved in ID
//   freeze                external hold of the whole pipe
//   pc_en, ifid_en        PC and IF/ID load enables
//   ifid_flush            clear IF/ID to NOP on the next edge
//   idex_bubble           load zero control bits into ID/EX
//   fwd_a_sel, fwd_b_sel  EX operand source: 0 = RF/ID-EX, k = stage k result
//
// Optional feature (macro HAZARD_PERF_EN)
//   Adds stall_cnt[15:0] and flush_cnt[15:0], saturating event counters
//   for stall cycles and flush cycles.

module pipe_hazard_unit #(
   parameter int RIDX_W   = 5,
   parameter int NSTAGE   = 3,
   parameter int LOAD_LAT = 1,
   parameter int SEL_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [RIDX_W-1:0] id_ra,
   input  logic [RIDX_W-1:0] id_rb,
   input  logic              id_use_ra,
   input  logic              id_use_rb,
   input  logic [RIDX_W-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_jump,
   input  logic              freeze,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [SEL_W-1:0]  fwd_a_sel,
   output logic [SEL_W-1:0]  fwd_b_sel
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic [RIDX_W-1:0] rd;
      logic              regwrite;
      logic              memread;
      logic [RIDX_W-1:0] ra;
      logic [RIDX_W-1:0] rb;
      logic              use_ra;
      logic              use_rb;
   } entry_t;

   entry_t              sb [NSTAGE];
   entry_t              id_entry;
   logic                lu_stall;
   logic [NSTAGE-1:1]   prod_ok;

   assign id_entry = '{valid:    1'b1,
                       rd:       id_rd,
                       regwrite: id_regwrite,
                       memread:  id_memread,
                       ra:       id_ra,
                       rb:       id_rb,
                       use_ra:   id_use_ra,
                       use_rb:   id_use_rb};

   // Scoreboard shift; a stalled or empty ID slot enters EX as a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NSTAGE; s++) sb[s] <= '0;
      end else if (!freeze) begin
         for (int s = NSTAGE-1; s >= 1; s--) sb[s] <= sb[s-1];
         if (id_valid && !lu_stall) sb[0] <= id_entry;
         else                       sb[0] <= '0;
      end
   end

   // A load is not forwardable until it is LOAD_LAT stages past MEM, so any
   // consumer in ID that reads it while it sits in stages 0..LOAD_LAT-1 waits.
   always_comb begin
      lu_stall = 1'b0;
      for (int s = 0; s < LOAD_LAT; s++) begin
         if (sb[s].valid && sb[s].memread && (sb[s].rd != '0) &&
             ((id_use_ra && (sb[s].rd == id_ra)) ||
              (id_use_rb && (sb[s].rd == id_rb))))
            lu_stall = 1'b1;
      end
   end

   // Stages whose result can legally be forwarded this cycle.
   always_comb begin
      prod_ok = '0;
      for (int s = 1; s < NSTAGE; s++) begin
         prod_ok[s] = sb[s].valid && sb[s].regwrite && (sb[s].rd != '0) &&
                      (!sb[s].memread || (s >= 1 + LOAD_LAT));
      end
   end

   // Walk from oldest to youngest so the nearest producer overwrites.
   always_comb begin
      fwd_a_sel = '0;
      fwd_b_sel = '0;
      for (int s = NSTAGE-1; s >= 1; s--) begin
         if (prod_ok[s] && sb[0].use_ra && (sb[s].rd == sb[0].ra))
            fwd_a_sel = SEL_W'(s);
         if (prod_ok[s] && sb[0].use_rb && (sb[s].rd == sb[0].rb))
            fwd_b_sel = SEL_W'(s);
      end
   end

   // Reset holds the front end and bubbles ID/EX; freeze holds everything
   // without injecting a bubble, since ID/EX itself is held too.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      if (!reset) begin
         if (freeze) begin
            idex_bubble = 1'b0;
         end else begin
            pc_en       = !lu_stall;
            ifid_en     = !lu_stall;
            ifid_flush  = id_valid && id_jump && !lu_stall;
            idex_bubble = lu_stall;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // A frozen cycle is not a stall cycle, even if the hazard is pending.
         if (lu_stall && !freeze && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (ifid_flush && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_ra, id_rb, id_rd;
   logic       id_use_ra, id_use_rb, id_regwrite, id_memread, id_jump;
   logic       freeze;

   // u0: default configuration (NSTAGE=3, LOAD_LAT=1)
   logic       pc_en_0, ifid_en_0, ifid_flush_0, idex_bubble_0;
   logic [1:0] fwd_a_sel_0, fwd_b_sel_0;
   // u1: NSTAGE=4, LOAD_LAT=2
   logic       pc_en_1, ifid_en_1, ifid_flush_1, idex_bubble_1;
   logic [1:0] fwd_a_sel_1, fwd_b_sel_1;
`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt_0, flush_cnt_0, stall_cnt_1, flush_cnt_1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_unit u0 (
`ifdef HAZARD_PERF_EN
      .stall_cnt(stall_cnt_0), .flush_cnt(flush_cnt_0),
`endif
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_jump(id_jump), .freeze(freeze),
      .pc_en(pc_en_0), .ifid_en(ifid_en_0), .ifid_flush(ifid_flush_0),
      .idex_bubble(idex_bubble_0), .fwd_a_sel(fwd_a_sel_0), .fwd_b_sel(fwd_b_sel_0)
   );

   pipe_hazard_unit #(.NSTAGE(4), .LOAD_LAT(2)) u1 (
`ifdef HAZARD_PERF_EN
      .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1),
`endif
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_jump(id_jump), .freeze(freeze),
      .pc_en(pc_en_1), .ifid_en(ifid_en_1), .ifid_flush(ifid_flush_1),
      .idex_bubble(idex_bubble_1), .fwd_a_sel(fwd_a_sel_1), .fwd_b_sel(fwd_b_sel_1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1-2 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub, input logic rw,
                        input logic mr, input logic jp);
      id_valid    = 1'b1;
      id_rd       = rd;
      id_ra       = ra;
      id_rb       = rb;
      id_use_ra   = ua;
      id_use_rb   = ub;
      id_regwrite = rw;
      id_memread  = mr;
      id_jump     = jp;
   endtask

   task automatic idle();
      id_valid    = 1'b0;
      id_rd       = '0;
      id_ra       = '0;
      id_rb       = '0;
      id_use_ra   = 1'b0;
      id_use_rb   = 1'b0;
      id_regwrite = 1'b0;
      id_memread  = 1'b0;
      id_jump     = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      freeze = 1'b0;
      idle();
      tick();
      tick();

      // Reset state
      check("rst_pc_en",   32'(pc_en_0),       32'd0);
      check("rst_ifid_en", 32'(ifid_en_0),     32'd0);
      check("rst_flush",   32'(ifid_flush_0),  32'd0);
      check("rst_bubble",  32'(idex_bubble_0), 32'd1);
      check("rst_fwd_a",   32'(fwd_a_sel_0),   32'd0);
      check("rst_fwd_b",   32'(fwd_b_sel_0),   32'd0);
      reset = 1'b0;
      settle();
      check("empty_pc_en", 32'(pc_en_0),       32'd1);
      check("empty_bub",   32'(idex_bubble_0), 32'd0);

      // lw r5 ; add r6 = r5 + r1 -> one stall cycle, then fwd_a from WB
      issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      check("lw_issue_pc_en", 32'(pc_en_0), 32'd1);
      tick();
      issue(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("lu_stall_pc_en",  32'(pc_en_0),       32'd0);
      check("lu_stall_ifid",   32'(ifid_en_0),     32'd0);
      check("lu_stall_bubble", 32'(idex_bubble_0), 32'd1);
      tick();
      settle();
      check("lu_release_pc_en",  32'(pc_en_0),       32'd1);
      check("lu_release_bubble", 32'(idex_bubble_0), 32'd0);
      tick();
      idle();
      settle();
      check("lu_fwd_a", 32'(fwd_a_sel_0), 32'd2);
      check("lu_fwd_b", 32'(fwd_b_sel_0), 32'd0);
      tick();

      // add r3,r1,r2 ; sub r4,r3,r3 ; or r7,r3,r9
      issue(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      tick();
      issue(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("alu_no_stall", 32'(pc_en_0), 32'd1);
      tick();
      issue(5'd7, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("alu_fwd_a_mem", 32'(fwd_a_sel_0), 32'd1);
      check("alu_fwd_b_mem", 32'(fwd_b_sel_0), 32'd1);
      tick();
      idle();
      settle();
      check("alu_fwd_a_wb", 32'(fwd_a_sel_0), 32'd2);
      check("alu_fwd_b_none", 32'(fwd_b_sel_0), 32'd0);
      tick();

      // add r0 ; lw r0 ; consumer of r0 -> no stall, no forwarding
      issue(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      tick();
      issue(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      tick();
      issue(5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("r0_no_stall", 32'(pc_en_0),       32'd1);
      check("r0_no_bub",   32'(idex_bubble_0), 32'd0);
      tick();
      idle();
      settle();
      check("r0_fwd_a", 32'(fwd_a_sel_0), 32'd0);
      check("r0_fwd_b", 32'(fwd_b_sel_0), 32'd0);
      tick();
      tick();
      tick();

      // Jump with no hazard -> flush for exactly one cycle
      issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      check("jmp_flush",  32'(ifid_flush_0), 32'd1);
      check("jmp_pc_en",  32'(pc_en_0),      32'd1);
      tick();
      idle();
      settle();
      check("jmp_flush_off", 32'(ifid_flush_0), 32'd0);
      tick();

      // lw r5 ; jr r5 -> stall wins, flush only once the stall clears
      issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      tick();
      issue(5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      check("jmp_haz_flush", 32'(ifid_flush_0), 32'd0);
      check("jmp_haz_pc_en", 32'(pc_en_0),      32'd0);
      tick();
      settle();
      check("jmp_haz_flush_late", 32'(ifid_flush_0), 32'd1);
      check("jmp_haz_pc_en_late", 32'(pc_en_0),      32'd1);
      tick();
      idle();
      settle();
      check("jmp_haz_flush_off", 32'(ifid_flush_0), 32'd0);
      tick();
      tick();
      tick();

      // Reset asserted on the stall cycle of lw r5 ; add r6 = r5 + r1
      issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      tick();
      issue(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("midrst_stall", 32'(pc_en_0), 32'd0);
      reset = 1'b1;
      settle();
      check("midrst_bubble", 32'(idex_bubble_0), 32'd1);
      check("midrst_pc_en",  32'(pc_en_0),       32'd0);
      check("midrst_fwd_a",  32'(fwd_a_sel_0),   32'd0);
      check("midrst_fwd_b",  32'(fwd_b_sel_0),   32'd0);
      tick();
      reset = 1'b0;
      settle();
      // The load is gone, so the still-presented add must not stall.
      check("postrst_pc_en",  32'(pc_en_0),       32'd1);
      check("postrst_bubble", 32'(idex_bubble_0), 32'd0);
      idle();
      tick();

      // u1 (NSTAGE=4, LOAD_LAT=2): lw r7 ; add r8 = r7 + r2 with a freeze
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      issue(5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      check("l2_lw_pc_en", 32'(pc_en_1), 32'd1);
      tick();
      issue(5'd8, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      check("l2_stall1_pc_en",  32'(pc_en_1),       32'd0);
      check("l2_stall1_bubble", 32'(idex_bubble_1), 32'd1);
      tick();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("frz_pc_en",  32'(pc_en_1),       32'd0);
         check("frz_ifid",   32'(ifid_en_1),     32'd0);
         check("frz_bubble", 32'(idex_bubble_1), 32'd0);
         tick();
      end
      freeze = 1'b0;
      settle();
      // Load must still be in MEM: second stall cycle.
      check("l2_stall2_pc_en",  32'(pc_en_1),       32'd0);
      check("l2_stall2_bubble", 32'(idex_bubble_1), 32'd1);
      tick();
      settle();
      check("l2_release_pc_en", 32'(pc_en_1), 32'd1);
      tick();
      idle();
      settle();
      check("l2_fwd_a", 32'(fwd_a_sel_1), 32'd3);
      check("l2_fwd_b", 32'(fwd_b_sel_1), 32'd0);
`ifdef HAZARD_PERF_EN
      check("l2_stall_cnt", 32'(stall_cnt_1), 32'd2);
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
